fetch_stage: RTL and testbench

//  Instruction-fetch front end of the LEGv8 datapath. Owns the program counter,

---
 rtl/legv8_pkg.sv | 19 +
 rtl/if_id_reg.sv | 54 +++++
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants, the fetch FSM state type and the image range check.
package legv8_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned XLEN       = 64;
  localparam int unsigned INSN_W     = 32;

  typedef enum logic {
    FETCH = 1'b0,
    END   = 1'b1
  } fetch_state_e;

  // The sum is taken in 65 bits, so an address near 2^64 cannot wrap back into range.
  function automatic logic fits_image(input logic [XLEN-1:0] addr,
                                      input int unsigned     imem_bytes);
    return ({1'b0, addr} + 65'(INSN_BYTES)) <= 65'(imem_bytes);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline slot: holds {valid, pc, instr}.
// Priority is flush > load > consume > hold.
module if_id_reg
  import legv8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              consume,
  input  logic [XLEN-1:0]   load_pc,
  input  logic [INSN_W-1:0] load_instr,
  output logic              valid,
  output logic [XLEN-1:0]   pc,
  output logic [INSN_W-1:0] instr
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INSN_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = '0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch front end.
// Holds the PC, a FETCH/END state machine, the IF/ID slot and a delivered-instruction counter.
module fetch_stage
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [63:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             redirect_valid,
  input  logic [63:0]      redirect_target,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [63:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic             fetch_done,
  output logic [CNT_W-1:0] fetch_count
);

  logic [XLEN-1:0] pc_q, pc_d;
  fetch_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            in_range, target_ok, slot_free, load_en, accept;
  logic [XLEN-1:0] target_aligned;

  assign imem_addr = pc_q;

  always_comb begin
    target_aligned = redirect_target & ~64'd3;
    in_range       = fits_image(pc_q, IMEM_BYTES);
    target_ok      = fits_image(target_aligned, IMEM_BYTES);
    slot_free      = !if_valid || id_ready;
    load_en        = (state_q == FETCH) && in_range && slot_free;
    accept         = if_valid && id_ready;

    pc_d    = pc_q;
    state_d = state_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, accept};

    // Redirect wins over load; the slot is flushed even when decode takes it this cycle.
    if (redirect_valid) begin
      pc_d    = target_aligned;
      state_d = target_ok ? FETCH : END;
    end else if (load_en) begin
      pc_d = pc_q + 64'(INSN_BYTES);
    end else if ((state_q == FETCH) && slot_free && !in_range) begin
      state_d = END;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_done  = (state_q == END);
  assign fetch_count = cnt_q;

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .load       (load_en),
    .consume    (accept),
    .load_pc    (pc_q),
    .load_instr (imem_data),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: the scoreboard holds the expected stream of instructions accepted by decode.
module tb_fetch_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_done;
  logic [31:0] fetch_count;

  logic [31:0] img [8];
  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  initial begin
    img[0] = 32'h8b1f03e5; img[1] = 32'hf84000a4;
    img[2] = 32'h8b040086; img[3] = 32'hf80010a6;
    img[4] = 32'hd503201f; img[5] = 32'h91000421;
    img[6] = 32'hcb020020; img[7] = 32'hb4000040;
  end

  assign imem_data = (imem_addr < 64'd32) ? img[imem_addr[4:2]] : 32'hdeadbeef;

  fetch_stage #(
    .RESET_PC   (64'h0),
    .IMEM_BYTES (32),
    .CNT_W      (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .fetch_done      (fetch_done),
    .fetch_count     (fetch_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = img[pc[4:2]];
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_slot(input string tag, input logic [63:0] pc, input logic [31:0] cnt);
    check_eq({tag, "_valid"}, 64'(if_valid), 64'd1);
    check_eq({tag, "_pc"}, if_pc, pc);
    check_eq({tag, "_instr"}, 64'(if_instr), 64'(img[pc[4:2]]));
    check_eq({tag, "_count"}, 64'(fetch_count), 64'(cnt));
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_valid"}, 64'(if_valid), 64'd0);
    check_eq({tag, "_pc"}, if_pc, 64'd0);
    check_eq({tag, "_instr"}, 64'(if_instr), 64'd0);
    check_eq({tag, "_count"}, 64'(fetch_count), 64'd0);
    check_eq({tag, "_addr"}, imem_addr, 64'd0);
    check_eq({tag, "_done"}, 64'(fetch_done), 64'd0);
  endtask

  // Decode-side monitor: whatever decode takes at the coming edge must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && if_valid && id_ready) begin
      check_eq("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("acc_pc", if_pc, e.pc);
        check_eq("acc_instr", 64'(if_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    rst = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;

    // Reset, then stream with a stall on pc4.
    tick();
    check_eq("rst1_valid", 64'(if_valid), 64'd0);
    tick();
    check_reset("rst2");
    push_exp(0); push_exp(4); push_exp(8); push_exp(8); push_exp(12);
    push_exp(16); push_exp(20); push_exp(24); push_exp(28);
    rst = 1'b0;
    tick(); check_slot("pc0", 64'd0, 0);
    tick(); check_slot("pc4", 64'd4, 1);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_slot("stall", 64'd4, 1);
      check_eq("stall_addr", imem_addr, 64'd8);
    end
    id_ready = 1'b1;
    tick(); check_slot("pc8", 64'd8, 2);

    // Redirect to an unaligned target while pc8 is in the slot.
    redirect_valid = 1'b1; redirect_target = 64'h9;
    tick();
    check_eq("flush_valid", 64'(if_valid), 64'd0);
    check_eq("flush_instr", 64'(if_instr), 64'd0);
    check_eq("flush_addr", imem_addr, 64'd8);
    check_eq("flush_count", 64'(fetch_count), 64'd3);
    redirect_valid = 1'b0;
    tick(); check_slot("refetch8", 64'd8, 3);

    // Run to the end of the image.
    for (int k = 3; k < 8; k++) begin
      tick();
      check_slot("run", 64'(4 * k), 32'(k + 1));
      check_eq("run_done", 64'(fetch_done), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("end_done", 64'(fetch_done), 64'd1);
      check_eq("end_valid", 64'(if_valid), 64'd0);
      check_eq("end_addr", imem_addr, 64'd32);
      check_eq("end_count", 64'(fetch_count), 64'd9);
    end

    // Redirect out of END back to 0.
    push_exp(0);
    redirect_valid = 1'b1; redirect_target = 64'h0;
    tick();
    check_eq("rd0_done", 64'(fetch_done), 64'd0);
    check_eq("rd0_valid", 64'(if_valid), 64'd0);
    check_eq("rd0_addr", imem_addr, 64'd0);
    redirect_valid = 1'b0;
    tick(); check_slot("rd0_slot", 64'd0, 9);

    // Redirect to the top of the address space: END at once, no wrap.
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("hi_done", 64'(fetch_done), 64'd1);
      check_eq("hi_valid", 64'(if_valid), 64'd0);
      check_eq("hi_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("hi_count", 64'(fetch_count), 64'd10);
      tick();
    end

    // Reset asserted in the middle of a stall.
    redirect_valid = 1'b1; redirect_target = 64'h0;
    tick();
    redirect_valid = 1'b0;
    tick(); check_slot("pre_rst", 64'd0, 10);
    id_ready = 1'b0;
    tick(); check_slot("pre_rst_stall", 64'd0, 10);
    rst = 1'b1;
    tick(); check_reset("mid_rst");
    push_exp(0);
    rst = 1'b0; id_ready = 1'b1;
    tick(); check_slot("post_rst0", 64'd0, 0);
    tick(); check_slot("post_rst4", 64'd4, 1);
    id_ready = 1'b0;
    tick();
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
